// File: rtl/i2c_write_arbiter_if.sv
// i2c_write_arbiter_if
//   Bundles the requester-side command/response signals and the I2C engine
//   handshake of i2c_write_arbiter.
//   master : arbiter view (drives accept/response pulses and the engine launch)
//   slave  : environment view (requesters plus the I2C byte-write engine)
//   Requester side : req_valid[1:0], req_addr0/1[6:0], req_data0/1[7:0],
//                    req_ready[1:0], rsp_done[1:0], rsp_err[1:0]
//   Engine side    : m_start, m_addr[6:0], m_data[7:0], m_done, m_nack
//   Status         : busy
interface i2c_write_arbiter_if;
    logic [1:0] req_valid;
    logic [6:0] req_addr0;
    logic [7:0] req_data0;
    logic [6:0] req_addr1;
    logic [7:0] req_data1;
    logic [1:0] req_ready;
    logic [1:0] rsp_done;
    logic [1:0] rsp_err;
    logic       m_start;
    logic [6:0] m_addr;
    logic [7:0] m_data;
    logic       m_done;
    logic       m_nack;
    logic       busy;

    modport master (
        input  req_valid, req_addr0, req_data0, req_addr1, req_data1,
        input  m_done, m_nack,
        output req_ready, rsp_done, rsp_err,
        output m_start, m_addr, m_data, busy
    );

    modport slave (
        output req_valid, req_addr0, req_data0, req_addr1, req_data1,
        output m_done, m_nack,
        input  req_ready, rsp_done, rsp_err,
        input  m_start, m_addr, m_data, busy
    );
endinterface

// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter
//   Shares one I2C byte-write engine between two requesters. Grants round-robin,
//   latches the winning address/data, launches the engine with a one-cycle
//   m_start pulse, retries NACKed writes after a short idle gap, aborts on a
//   watchdog timeout and returns a done/err pulse to the owning requester.
//   Ports:
//     clk  - system clock, posedge
//     rst  - asynchronous active-low reset
//     bus  - i2c_write_arbiter_if.master (requester and engine handshakes, busy)
//   All outputs are registered.
module i2c_write_arbiter #(
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RETRY_GAP      = 4
) (
    input  logic                clk,
    input  logic                rst,
    i2c_write_arbiter_if.master bus
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        RESP
    } state_e;

    state_e          state_q;
    logic            rr_ptr_q;
    logic            owner_q;
    logic [RW-1:0]   retry_cnt_q;
    logic [TW-1:0]   timer_q;
    logic [GW-1:0]   gap_q;
    logic [1:0]      req_ready_q;
    logic [1:0]      rsp_done_q;
    logic [1:0]      rsp_err_q;
    logic            m_start_q;
    logic [6:0]      m_addr_q;
    logic [7:0]      m_data_q;
    logic            busy_q;
    logic            grant_d;

    // Contention resolves to the round-robin pointer; otherwise the lone requester wins.
    always_comb begin
        grant_d = 1'b0;
        if (bus.req_valid == 2'b11) begin
            grant_d = rr_ptr_q;
        end else begin
            grant_d = bus.req_valid[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            retry_cnt_q <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            req_ready_q <= '0;
            rsp_done_q  <= '0;
            rsp_err_q   <= '0;
            m_start_q   <= 1'b0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises only what it needs.
            req_ready_q <= '0;
            rsp_done_q  <= '0;
            rsp_err_q   <= '0;
            m_start_q   <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        req_ready_q[grant_d] <= 1'b1;
                        m_addr_q    <= grant_d ? bus.req_addr1 : bus.req_addr0;
                        m_data_q    <= grant_d ? bus.req_data1 : bus.req_data0;
                        owner_q     <= grant_d;
                        rr_ptr_q    <= ~grant_d;
                        retry_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end

                ISSUE: begin
                    m_start_q <= 1'b1;
                    timer_q   <= '0;
                    state_q   <= WAIT;
                end

                WAIT: begin
                    // m_done has priority over the watchdog on the terminal cycle.
                    if (bus.m_done) begin
                        if (!bus.m_nack) begin
                            rsp_done_q[owner_q] <= 1'b1;
                            state_q             <= RESP;
                        end else if (retry_cnt_q < RW'(MAX_RETRY)) begin
                            retry_cnt_q <= retry_cnt_q + 1'b1;
                            gap_q       <= '0;
                            state_q     <= (RETRY_GAP == 0) ? ISSUE : GAP;
                        end else begin
                            rsp_done_q[owner_q] <= 1'b1;
                            rsp_err_q[owner_q]  <= 1'b1;
                            state_q             <= RESP;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_done_q[owner_q] <= 1'b1;
                        rsp_err_q[owner_q]  <= 1'b1;
                        state_q             <= RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                GAP: begin
                    if (gap_q == GW'(RETRY_GAP - 1)) begin
                        state_q <= ISSUE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end

                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_done  = rsp_done_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.m_start   = m_start_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_data    = m_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_i2c_write_arbiter.sv
// tb_i2c_write_arbiter
//   Scenario tasks for i2c_write_arbiter with a small reference model:
//   round-robin grant rule, attempt/outcome rule for ACK/NACK/timeout, and
//   the fixed latencies (grant->start, done->retry start, start->timeout).
module tb_i2c_write_arbiter;
    localparam int unsigned MAX_RETRY = 2;
    localparam int unsigned TIMEOUT   = 40;
    localparam int unsigned GAP       = 4;
    localparam int B_ACK  = 0;
    localparam int B_NACK = 1;
    localparam int B_TMO  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   model_ptr = 1'b0;
    logic [6:0] addr_m [2];
    logic [7:0] data_m [2];

    i2c_write_arbiter_if bus_if ();

    i2c_write_arbiter #(
        .MAX_RETRY      (MAX_RETRY),
        .TIMEOUT_CYCLES (TIMEOUT),
        .RETRY_GAP      (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmds();
        bus_if.req_addr0 = addr_m[0];
        bus_if.req_data0 = data_m[0];
        bus_if.req_addr1 = addr_m[1];
        bus_if.req_data1 = data_m[1];
    endtask

    task automatic new_cmd(input int r);
        addr_m[r] = 7'($urandom);
        data_m[r] = 8'($urandom);
        drive_cmds();
    endtask

    task automatic idle_inputs();
        bus_if.req_valid = 2'b00;
        bus_if.m_done    = 1'b0;
        bus_if.m_nack    = 1'b0;
        drive_cmds();
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        model_ptr = 1'b0;
        tick();
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus_if.req_ready == 2'b00 && n < limit);
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (!bus_if.m_start && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus_if.rsp_done == 2'b00 && n < limit);
    endtask

    task automatic engine_reply(input int delay, input bit nack);
        repeat (delay - 1) tick();
        bus_if.m_done = 1'b1;
        bus_if.m_nack = nack;
        tick();
        bus_if.m_done = 1'b0;
        bus_if.m_nack = 1'b0;
    endtask

    function automatic bit model_grant(input logic [1:0] pend, input bit ptr);
        return (pend == 2'b11) ? ptr : pend[1];
    endfunction

    // Attempts stop at the first ACK or timeout, or after MAX_RETRY+1 NACKs.
    function automatic void model_outcome(input int beh [3], output int attempts, output bit err);
        attempts = 0;
        err      = 1'b1;
        for (int k = 0; k <= int'(MAX_RETRY); k++) begin
            attempts = k + 1;
            if (beh[k] == B_ACK) begin
                err = 1'b0;
                break;
            end
            if (beh[k] == B_TMO) break;
        end
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        checks++; if (bus_if.m_start !== 1'b0) begin errors++; $display("FAIL reset_m_start got=%b exp=0", bus_if.m_start); end
        checks++; if ({bus_if.req_ready, bus_if.rsp_done, bus_if.rsp_err} !== 6'h00) begin
            errors++; $display("FAIL reset_pulses got=%b_%b_%b exp=00_00_00", bus_if.req_ready, bus_if.rsp_done, bus_if.rsp_err);
        end
        checks++; if ({bus_if.m_addr, bus_if.m_data} !== 15'h0) begin
            errors++; $display("FAIL reset_latch got=%h/%h exp=00/00", bus_if.m_addr, bus_if.m_data);
        end
        rst = 1'b1;
        model_ptr = 1'b0;
        tick();
    endtask

    task automatic test_single();
        addr_m[0] = 7'h50;
        data_m[0] = 8'hAA;
        drive_cmds();
        bus_if.req_valid = 2'b01;
        tick();
        checks++; if (bus_if.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", bus_if.req_ready); end
        bus_if.req_valid = 2'b00;
        checks++; if (bus_if.m_start !== 1'b0) begin errors++; $display("FAIL single_early_start got=%b exp=0", bus_if.m_start); end
        tick();
        checks++; if (bus_if.m_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", bus_if.m_start); end
        checks++; if (bus_if.req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_pulse got=%b exp=00", bus_if.req_ready); end
        checks++; if (bus_if.m_addr !== 7'h50 || bus_if.m_data !== 8'hAA) begin
            errors++; $display("FAIL single_latch got=%h/%h exp=50/aa", bus_if.m_addr, bus_if.m_data);
        end
        engine_reply(30, 1'b0);
        checks++; if (bus_if.rsp_done !== 2'b01 || bus_if.rsp_err !== 2'b00) begin
            errors++; $display("FAIL single_rsp got=%b/%b exp=01/00", bus_if.rsp_done, bus_if.rsp_err);
        end
        tick();
        checks++; if (bus_if.rsp_done !== 2'b00 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL single_after got done=%b busy=%b exp=00/0", bus_if.rsp_done, bus_if.busy);
        end
        model_ptr = 1'b1;
    endtask

    task automatic test_contention();
        int n;
        bit g;
        logic [1:0] oh;
        logic [6:0] ea;
        logic [7:0] ed;
        apply_reset();
        new_cmd(0);
        new_cmd(1);
        bus_if.req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            g = model_grant(2'b11, model_ptr);
            model_ptr = ~g;
            oh = 2'b01 << g;
            ea = addr_m[g];
            ed = data_m[g];
            wait_ready(20, n);
            checks++; if (bus_if.req_ready !== oh) begin errors++; $display("FAIL contend_grant[%0d] got=%b exp=%b", t, bus_if.req_ready, oh); end
            new_cmd(int'(g));
            wait_start(5, n);
            checks++; if (!bus_if.m_start || n != 1) begin errors++; $display("FAIL contend_start[%0d] got=%0d cycles exp=1", t, n); end
            checks++; if (bus_if.m_addr !== ea || bus_if.m_data !== ed) begin
                errors++; $display("FAIL contend_latch[%0d] got=%h/%h exp=%h/%h", t, bus_if.m_addr, bus_if.m_data, ea, ed);
            end
            engine_reply(int'($urandom_range(1, 20)), 1'b0);
            checks++; if (bus_if.rsp_done !== oh || bus_if.rsp_err !== 2'b00) begin
                errors++; $display("FAIL contend_rsp[%0d] got=%b/%b exp=%b/00", t, bus_if.rsp_done, bus_if.rsp_err, oh);
            end
        end
        bus_if.req_valid = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_nack_retry();
        int n;
        logic [6:0] ea;
        logic [7:0] ed;
        apply_reset();
        new_cmd(0);
        ea = addr_m[0];
        ed = data_m[0];
        bus_if.req_valid = 2'b01;
        wait_ready(5, n);
        checks++; if (bus_if.req_ready !== 2'b01) begin errors++; $display("FAIL retry_grant got=%b exp=01", bus_if.req_ready); end
        bus_if.req_valid = 2'b00;
        new_cmd(0);
        for (int k = 0; k < 3; k++) begin
            wait_start(20, n);
            checks++; if (!bus_if.m_start || n != ((k == 0) ? 1 : int'(GAP) + 1)) begin
                errors++; $display("FAIL retry_start[%0d] got=%0d cycles exp=%0d", k, n, (k == 0) ? 1 : int'(GAP) + 1);
            end
            checks++; if (bus_if.m_addr !== ea || bus_if.m_data !== ed) begin
                errors++; $display("FAIL retry_latch[%0d] got=%h/%h exp=%h/%h", k, bus_if.m_addr, bus_if.m_data, ea, ed);
            end
            engine_reply(int'($urandom_range(1, 10)), k < 2);
        end
        checks++; if (bus_if.rsp_done !== 2'b01 || bus_if.rsp_err !== 2'b00) begin
            errors++; $display("FAIL retry_rsp got=%b/%b exp=01/00", bus_if.rsp_done, bus_if.rsp_err);
        end
        model_ptr = 1'b1;
        tick();
    endtask

    task automatic test_nack_exhaust();
        int n;
        int extra;
        new_cmd(1);
        bus_if.req_valid = 2'b10;
        wait_ready(5, n);
        checks++; if (bus_if.req_ready !== 2'b10) begin errors++; $display("FAIL exhaust_grant got=%b exp=10", bus_if.req_ready); end
        bus_if.req_valid = 2'b00;
        model_ptr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_start(20, n);
            checks++; if (!bus_if.m_start) begin errors++; $display("FAIL exhaust_start[%0d] got=0 exp=1", k); end
            engine_reply(int'($urandom_range(1, 10)), 1'b1);
            if (k < 2) begin
                checks++; if (bus_if.rsp_done !== 2'b00) begin errors++; $display("FAIL exhaust_early_rsp[%0d] got=%b exp=00", k, bus_if.rsp_done); end
            end
        end
        checks++; if (bus_if.rsp_done !== 2'b10 || bus_if.rsp_err !== 2'b10) begin
            errors++; $display("FAIL exhaust_rsp got=%b/%b exp=10/10", bus_if.rsp_done, bus_if.rsp_err);
        end
        extra = 0;
        repeat (12) begin
            tick();
            if (bus_if.m_start) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL exhaust_extra_start got=%0d exp=0", extra); end
    endtask

    task automatic test_timeout();
        int n;
        new_cmd(0);
        bus_if.req_valid = 2'b01;
        wait_ready(5, n);
        bus_if.req_valid = 2'b00;
        model_ptr = 1'b1;
        wait_start(5, n);
        wait_rsp(int'(TIMEOUT) + 10, n);
        checks++; if (bus_if.rsp_done !== 2'b01 || n != int'(TIMEOUT)) begin
            errors++; $display("FAIL timeout_latency got=%0d cycles done=%b exp=%0d/01", n, bus_if.rsp_done, TIMEOUT);
        end
        checks++; if (bus_if.rsp_err !== 2'b01) begin errors++; $display("FAIL timeout_err got=%b exp=01", bus_if.rsp_err); end
        tick();
        new_cmd(1);
        bus_if.req_valid = 2'b10;
        wait_ready(5, n);
        bus_if.req_valid = 2'b00;
        model_ptr = 1'b0;
        wait_start(5, n);
        repeat (TIMEOUT - 1) tick();
        bus_if.m_done = 1'b1;
        bus_if.m_nack = 1'b0;
        tick();
        bus_if.m_done = 1'b0;
        checks++; if (bus_if.rsp_done !== 2'b10 || bus_if.rsp_err !== 2'b00) begin
            errors++; $display("FAIL timeout_done_wins got=%b/%b exp=10/00", bus_if.rsp_done, bus_if.rsp_err);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int seen_done;
        new_cmd(0);
        bus_if.req_valid = 2'b01;
        wait_ready(5, n);
        bus_if.req_valid = 2'b00;
        wait_start(5, n);
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus_if.busy !== 1'b0 || bus_if.m_start !== 1'b0) begin
            errors++; $display("FAIL midrst_async got busy=%b start=%b exp=0/0", bus_if.busy, bus_if.m_start);
        end
        checks++; if (bus_if.m_addr !== 7'h00 || bus_if.m_data !== 8'h00) begin
            errors++; $display("FAIL midrst_latch got=%h/%h exp=00/00", bus_if.m_addr, bus_if.m_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_ptr = 1'b0;
        bus_if.m_done = 1'b1;
        tick();
        bus_if.m_done = 1'b0;
        seen_done = 0;
        repeat (8) begin
            tick();
            if (bus_if.rsp_done != 2'b00 || bus_if.m_start) seen_done++;
        end
        checks++; if (seen_done != 0 || bus_if.busy !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet got=%0d events busy=%b exp=0/0", seen_done, bus_if.busy);
        end
        bus_if.req_valid = 2'b11;
        wait_ready(5, n);
        checks++; if (bus_if.req_ready !== 2'b01) begin errors++; $display("FAIL midrst_regrant got=%b exp=01", bus_if.req_ready); end
        bus_if.req_valid = 2'b00;
        model_ptr = 1'b1;
        wait_start(5, n);
        engine_reply(3, 1'b0);
        checks++; if (bus_if.rsp_done !== 2'b01) begin errors++; $display("FAIL midrst_rsp got=%b exp=01", bus_if.rsp_done); end
        tick();
    endtask

    task automatic test_random();
        int n;
        int attempts;
        int beh [3];
        bit exp_err;
        bit g;
        logic [1:0] pend;
        logic [1:0] oh;
        logic [6:0] ea;
        logic [7:0] ed;
        int exp_n;
        apply_reset();
        pend = 2'b00;
        for (int tr = 0; tr < 25; tr++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    new_cmd(r);
                end
            end
            if (pend == 2'b00) begin
                pend[0] = 1'b1;
                new_cmd(0);
            end
            bus_if.req_valid = pend;
            g = model_grant(pend, model_ptr);
            model_ptr = ~g;
            oh = 2'b01 << g;
            ea = addr_m[g];
            ed = data_m[g];
            for (int k = 0; k < 3; k++) begin
                n = int'($urandom_range(0, 9));
                beh[k] = (n < 5) ? B_ACK : ((n < 9) ? B_NACK : B_TMO);
            end
            model_outcome(beh, attempts, exp_err);
            wait_ready(10, n);
            checks++; if (bus_if.req_ready !== oh) begin errors++; $display("FAIL rand_grant[%0d] got=%b exp=%b", tr, bus_if.req_ready, oh); end
            pend[g] = 1'b0;
            bus_if.req_valid = pend;
            for (int k = 0; k < attempts; k++) begin
                exp_n = (k == 0) ? 1 : int'(GAP) + 1;
                wait_start(20, n);
                checks++; if (!bus_if.m_start || n != exp_n || bus_if.m_addr !== ea || bus_if.m_data !== ed) begin
                    errors++; $display("FAIL rand_start[%0d.%0d] got=%0d cycles %h/%h exp=%0d cycles %h/%h",
                                       tr, k, n, bus_if.m_addr, bus_if.m_data, exp_n, ea, ed);
                end
                if (beh[k] == B_TMO) begin
                    wait_rsp(int'(TIMEOUT) + 10, n);
                    checks++; if (n != int'(TIMEOUT)) begin errors++; $display("FAIL rand_timeout[%0d] got=%0d exp=%0d", tr, n, TIMEOUT); end
                end else begin
                    engine_reply(int'($urandom_range(1, 15)), beh[k] == B_NACK);
                end
            end
            checks++; if (bus_if.rsp_done !== oh || bus_if.rsp_err !== (exp_err ? oh : 2'b00)) begin
                errors++; $display("FAIL rand_rsp[%0d] got=%b/%b exp=%b/%b", tr, bus_if.rsp_done, bus_if.rsp_err, oh, exp_err ? oh : 2'b00);
            end
            tick();
        end
        bus_if.req_valid = 2'b00;
        tick();
    endtask

    initial begin
        addr_m[0] = '0;
        data_m[0] = '0;
        addr_m[1] = '0;
        data_m[1] = '0;
        test_reset();
        test_single();
        test_contention();
        test_nack_retry();
        test_nack_exhaust();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
